// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + 3-state issue FSM in front of a combinational ALU_nbit; captures o/co into a
// handshaked result register. Optional res_zero flag enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_cmd_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_sel,
  input  logic [N-1:0]             cmd_a,
  input  logic [N-1:0]             cmd_b,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic [2:0]               alu_sel,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  input  logic [N-1:0]             alu_o,
  input  logic                     alu_co,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N-1:0]             res_o,
  output logic                     res_co
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic                     res_zero
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      fifo_sel [DEPTH];
  logic [N-1:0]    fifo_a   [DEPTH];
  logic [N-1:0]    fifo_b   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, capture, res_clr;

  // Ready depends only on registered count, so a full FIFO never accepts even when popping.
  assign cmd_ready = !rst && (count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign cmd_count = count;

  // FIFO stage: storage is data-only, pointers/count are control
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sel[wr_ptr] <= cmd_sel;
      fifo_a[wr_ptr]   <= cmd_a;
      fifo_b[wr_ptr]   <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    res_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (res_ready) begin
          res_clr = 1'b1;
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: ALU operands hold their last value between commands to avoid toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (pop) begin
      alu_sel <= fifo_sel[rd_ptr];
      alu_a   <= fifo_a[rd_ptr];
      alu_b   <= fifo_b[rd_ptr];
    end
  end

  // Result stage: ALU output sampled after operands were stable for a full cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_o     <= '0;
      res_co    <= 1'b0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_o     <= alu_o;
        res_co    <= alu_co;
      end else if (res_clr) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  always_ff @(posedge clk) begin
    if (rst)          res_zero <= 1'b0;
    else if (capture) res_zero <= (alu_o == {N{1'b0}});
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Table-driven bench for alu_cmd_sequencer with an XOR/AND stub standing in for ALU_nbit.
module tb_alu_cmd_sequencer;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_sel;
  logic [N-1:0] cmd_a, cmd_b;
  logic [$clog2(DEPTH):0] cmd_count;
  logic [2:0]   alu_sel;
  logic [N-1:0] alu_a, alu_b, alu_o;
  logic         alu_co;
  logic         res_valid, res_ready;
  logic [N-1:0] res_o;
  logic         res_co;
`ifdef ALU_SEQ_ZFLAG_EN
  logic         res_zero;
`endif

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_count(cmd_count),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_co(alu_co),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_o(res_o), .res_co(res_co)
`ifdef ALU_SEQ_ZFLAG_EN
    , .res_zero(res_zero)
`endif
  );

  assign alu_o  = alu_a ^ alu_b;
  assign alu_co = alu_a[N-1] & alu_b[N-1];

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] o;
    logic         co;
  } vec_t;

  vec_t         tv [8];
  logic [2:0]   qs [16];
  logic [N-1:0] qa [16];
  logic [N-1:0] qb [16];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command through an idle sequencer with res_ready=1, checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sel = v.sel; cmd_a = v.a; cmd_b = v.b;
    check("vec_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("vec_count_t", 32'(cmd_count), 32'd1);
    check("vec_valid_t", 32'(res_valid), 32'd0);
    step();
    check("vec_alu_sel", 32'(alu_sel), 32'(v.sel));
    check("vec_alu_a", 32'(alu_a), 32'(v.a));
    check("vec_alu_b", 32'(alu_b), 32'(v.b));
    check("vec_valid_t1", 32'(res_valid), 32'd0);
    step();
    check("vec_valid_t2", 32'(res_valid), 32'd1);
    check("vec_res_o", 32'(res_o), 32'(v.o));
    check("vec_res_co", 32'(res_co), 32'(v.co));
    step();
    check("vec_valid_t3", 32'(res_valid), 32'd0);
  endtask

  // Push qs/qa/qb[0..n-1] back-to-back, with a bounded wait per command.
  task automatic push_n(input int n);
    int  pi  = 0;
    int  cyc = 0;
    bit  acc;
    while (pi < n && cyc < 50) begin
      cmd_valid = 1'b1; cmd_sel = qs[pi]; cmd_a = qa[pi]; cmd_b = qb[pi];
      acc = cmd_ready;
      step();
      if (acc) pi++;
      cyc++;
    end
    cmd_valid = 1'b0;
    check("push_done", 32'(pi), 32'(n));
  endtask

  // Keep pushing from start_pi and collect n results in order against the XOR/AND model.
  task automatic stream(input int start_pi, input int n, input bit chk_gap);
    int pi = start_pi;
    int ri = 0;
    int cyc = 0;
    int last = 0;
    bit acc, take;
    logic [N-1:0] eo;
    while (ri < n && cyc < 400) begin
      cmd_valid = (pi < n);
      if (pi < n) begin
        cmd_sel = qs[pi]; cmd_a = qa[pi]; cmd_b = qb[pi];
      end
      acc  = cmd_valid && cmd_ready;
      take = res_valid && res_ready;
      if (take) begin
        eo = qa[ri] ^ qb[ri];
        check("stream_res_o", 32'(res_o), 32'(eo));
        check("stream_res_co", 32'(res_co), 32'(qa[ri][N-1] & qb[ri][N-1]));
        if (chk_gap && ri > 0) check("stream_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        ri++;
      end
      step();
      if (acc) pi++;
      cyc++;
    end
    cmd_valid = 1'b0;
    check("stream_done", 32'(ri), 32'(n));
  endtask

  initial begin
    tv[0] = '{3'd2, 4'hA, 4'h6, 4'hC, 1'b0};
    tv[1] = '{3'd0, 4'hF, 4'hF, 4'h0, 1'b1};
    tv[2] = '{3'd1, 4'h8, 4'h7, 4'hF, 1'b0};
    tv[3] = '{3'd7, 4'hC, 4'hA, 4'h6, 1'b1};
    tv[4] = '{3'd3, 4'h0, 4'h0, 4'h0, 1'b0};
    tv[5] = '{3'd5, 4'h5, 4'hA, 4'hF, 1'b0};
    tv[6] = '{3'd4, 4'h9, 4'h9, 4'h0, 1'b1};
    tv[7] = '{3'd6, 4'h3, 4'hC, 4'hF, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    step(); step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_o", 32'(res_o), 32'd0);
    check("rst_res_co", 32'(res_co), 32'd0);
    check("rst_alu", {alu_sel, alu_a, alu_b}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Fill with backpressure: first command parks in WAIT, four queue up, sixth waits.
    for (int k = 0; k < 6; k++) begin
      qs[k] = 3'(k); qa[k] = 4'(9 + k); qb[k] = 4'(12 - k);
    end
    res_ready = 1'b0;
    push_n(5);
    cmd_valid = 1'b1; cmd_sel = qs[5]; cmd_a = qa[5]; cmd_b = qb[5];
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(cmd_count), 32'd4);
    check("full_valid", 32'(res_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_res", {res_valid, res_co, res_o}, {26'd0, 1'b1, 1'b1, 4'h5});
      check("hold_alu", {alu_sel, alu_a, alu_b}, {21'd0, 3'd0, 4'h9, 4'hC});
      check("hold_count", 32'(cmd_count), 32'd4);
    end
    res_ready = 1'b1;
    stream(5, 6, 1'b0);
    check("fill_count_end", 32'(cmd_count), 32'd0);
    check("fill_valid_end", 32'(res_valid), 32'd0);

    // Pointer wrap with sustained streaming.
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      qs[k] = 3'(k); qa[k] = 4'(k); qb[k] = 4'h0;
    end
    step();
    stream(0, 3 * DEPTH + 1, 1'b1);
    step();
    check("wrap_count_end", 32'(cmd_count), 32'd0);

    // Reset while a result waits and three commands are queued.
    for (int k = 0; k < 4; k++) begin
      qs[k] = 3'd1; qa[k] = 4'(k + 3); qb[k] = 4'h1;
    end
    res_ready = 1'b0;
    push_n(4);
    check("mid_count", 32'(cmd_count), 32'd3);
    check("mid_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready_comb", 32'(cmd_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_count", 32'(cmd_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_data", {alu_a, alu_b, res_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 32'(cmd_ready), 32'd1);
    run_vec(tv[3]);
    step(); step();
    check("mid_idle_valid", 32'(res_valid), 32'd0);
    check("mid_idle_count", 32'(cmd_count), 32'd0);

`ifdef ALU_SEQ_ZFLAG_EN
    run_vec('{3'd0, 4'h5, 4'h5, 4'h0, 1'b0});
    check("zflag_set", 32'(res_zero), 32'd1);
    run_vec('{3'd0, 4'h5, 4'h4, 4'h1, 1'b0});
    check("zflag_clr", 32'(res_zero), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
